// File: rtl/line_follow_pi.sv
// Line-follower PI controller: scans IR emitter/receiver pairs through an external A2D,
// forms a weighted position error and drives left/right motor commands.
module line_follow_pi #(
    parameter int          NUM_PAIRS  = 3,
    parameter int          SETTLE_CYC = 4095,
    parameter int          INT_DEC    = 4,
    parameter logic [7:0]  KP         = 8'h36,
    parameter logic [7:0]  KI         = 8'h05,
    parameter logic [11:0] FWD_MAX    = 12'h700,
    parameter int          MOT_W      = 11,
    parameter int          CNV_TO     = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 cnv_cmplt,
    input  logic [11:0]          A2D_res,
    output logic                 strt_cnv,
    output logic [2:0]           chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [7:0]           LEDs,
    output logic [MOT_W-1:0]     lft,
    output logic [MOT_W-1:0]     rht,
    output logic                 upd,
    output logic                 a2d_err
);

    localparam int         TO_W      = (CNV_TO > 1) ? $clog2(CNV_TO + 1) : 1;
    localparam logic [1:0] LAST_PAIR = 2'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CONV, CALC_ERR, INTG, PI, MOTOR} state_t;

    state_t                r_state;
    logic [1:0]            r_pair;
    logic                  r_side;
    logic [15:0]           r_settle_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [4:0]            r_dec;
    logic signed [15:0]    r_accum;
    logic signed [11:0]    r_error;
    logic signed [11:0]    r_intgrl;
    logic [11:0]           r_fwd;
    logic signed [15:0]    r_pcomp;
    logic signed [15:0]    r_icomp;
    logic [11:0]           r_lft_reg;
    logic [11:0]           r_rht_reg;
    logic                  r_strt;
    logic [2:0]            r_chnnl;
    logic [NUM_PAIRS-1:0]  r_ir_en;
    logic                  r_upd;
    logic                  r_err;

    logic [15:0]           w_shifted;
    logic [1:0]            w_pair_next;
    logic [4:0]            w_dec_next;
    logic signed [20:0]    w_pprod;
    logic signed [20:0]    w_iprod;
    logic signed [17:0]    w_fwd18;
    logic signed [17:0]    w_pi18;
    logic signed [17:0]    w_lft_sum;
    logic signed [17:0]    w_rht_sum;

    function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
        if (v > 16'sd2047)
            return 12'h7FF;
        else if (v < -16'sd2048)
            return 12'h800;
        else
            return v[11:0];
    endfunction

    function automatic logic [11:0] clamp12(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 12'h000;
        else if (v > 18'sd4095)
            return 12'hFFF;
        else
            return v[11:0];
    endfunction

    // Pair weighting is a plain shift by the pair index.
    assign w_shifted   = 16'(A2D_res) << r_pair;
    assign w_pair_next = r_pair + 2'd1;
    assign w_dec_next  = r_dec + 5'd1;
    assign w_pprod     = 21'(r_error)  * 21'($signed({1'b0, KP}));
    assign w_iprod     = 21'(r_intgrl) * 21'($signed({1'b0, KI}));
    assign w_fwd18     = $signed({6'b000000, r_fwd});
    assign w_pi18      = 18'(r_pcomp) + 18'(r_icomp);
    assign w_lft_sum   = w_fwd18 + w_pi18;
    assign w_rht_sum   = w_fwd18 - w_pi18;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pair       <= 2'd0;
            r_side       <= 1'b0;
            r_settle_cnt <= 16'd0;
            r_to_cnt     <= '0;
            r_dec        <= 5'd0;
            r_accum      <= 16'sd0;
            r_error      <= 12'sd0;
            r_intgrl     <= 12'sd0;
            r_fwd        <= 12'd0;
            r_pcomp      <= 16'sd0;
            r_icomp      <= 16'sd0;
            r_lft_reg    <= 12'd0;
            r_rht_reg    <= 12'd0;
            r_strt       <= 1'b0;
            r_chnnl      <= 3'd0;
            r_ir_en      <= '0;
            r_upd        <= 1'b0;
            r_err        <= 1'b0;
        end else if (!go) begin
            // Stopping parks the robot but keeps Error so the LEDs still show the last reading.
            r_state   <= IDLE;
            r_ir_en   <= '0;
            r_strt    <= 1'b0;
            r_upd     <= 1'b0;
            r_fwd     <= 12'd0;
            r_intgrl  <= 12'sd0;
            r_dec     <= 5'd0;
            r_lft_reg <= 12'd0;
            r_rht_reg <= 12'd0;
            r_err     <= 1'b0;
        end else begin
            r_strt <= 1'b0;
            r_upd  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_accum      <= 16'sd0;
                    r_pair       <= 2'd0;
                    r_side       <= 1'b0;
                    r_settle_cnt <= 16'd0;
                    r_ir_en      <= NUM_PAIRS'(1);
                    r_state      <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle_cnt == 16'(SETTLE_CYC - 1)) begin
                        r_settle_cnt <= 16'd0;
                        r_chnnl      <= {r_pair, r_side};
                        r_strt       <= 1'b1;
                        r_to_cnt     <= '0;
                        r_state      <= CONV;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 16'd1;
                    end
                end
                CONV: begin
                    if (cnv_cmplt) begin
                        if (!r_side) begin
                            r_accum <= r_accum + w_shifted;
                            r_side  <= 1'b1;
                            r_state <= SETTLE;
                        end else begin
                            r_accum <= r_accum - w_shifted;
                            r_side  <= 1'b0;
                            if (r_pair == LAST_PAIR) begin
                                r_ir_en <= '0;
                                r_state <= CALC_ERR;
                            end else begin
                                r_pair  <= w_pair_next;
                                r_ir_en <= NUM_PAIRS'(1) << w_pair_next;
                                r_state <= SETTLE;
                            end
                        end
                    end else if (r_to_cnt == TO_W'(CNV_TO - 1)) begin
                        r_err   <= 1'b1;
                        r_ir_en <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                CALC_ERR: begin
                    r_error <= sat12(r_accum);
                    r_state <= INTG;
                end
                INTG: begin
                    if (w_dec_next == 5'(INT_DEC)) begin
                        r_intgrl <= sat12(16'(r_intgrl) + 16'(r_error));
                        r_dec    <= 5'd0;
                    end else begin
                        r_dec    <= w_dec_next;
                    end
                    if (r_fwd < FWD_MAX)
                        r_fwd <= r_fwd + 12'd1;
                    r_state <= PI;
                end
                PI: begin
                    r_pcomp <= 16'(w_pprod >>> 4);
                    r_icomp <= 16'(w_iprod >>> 4);
                    r_state <= MOTOR;
                end
                MOTOR: begin
                    r_lft_reg <= clamp12(w_lft_sum);
                    r_rht_reg <= clamp12(w_rht_sum);
                    r_upd     <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign strt_cnv = r_strt;
    assign chnnl    = r_chnnl;
    assign IR_en    = r_ir_en;
    assign LEDs     = r_error[11:4];
    assign lft      = r_lft_reg[11:12-MOT_W];
    assign rht      = r_rht_reg[11:12-MOT_W];
    assign upd      = r_upd;
    assign a2d_err  = r_err;

endmodule

// File: tb/tb_line_follow_pi.sv
// Directed bench for line_follow_pi: a 3-pair/11-bit instance and a 1-pair/12-bit instance,
// each fed by a small A2D responder model.
module tb_line_follow_pi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic goA = 1'b0;
    logic goB = 1'b0;

    logic        cnvA = 1'b0;
    logic [11:0] resA = 12'd0;
    logic        strtA;
    logic [2:0]  chA;
    logic [2:0]  irA;
    logic [7:0]  ledsA;
    logic [10:0] lftA;
    logic [10:0] rhtA;
    logic        updA;
    logic        errA;

    logic        cnvB = 1'b0;
    logic [11:0] resB = 12'd0;
    logic        strtB;
    logic [2:0]  chB;
    logic [0:0]  irB;
    logic [7:0]  ledsB;
    logic [11:0] lftB;
    logic [11:0] rhtB;
    logic        updB;
    logic        errB;

    line_follow_pi #(
        .NUM_PAIRS(3), .SETTLE_CYC(8), .INT_DEC(4), .FWD_MAX(12'h006), .MOT_W(11), .CNV_TO(20)
    ) dutA (
        .clk(clk), .rst(rst), .go(goA), .cnv_cmplt(cnvA), .A2D_res(resA),
        .strt_cnv(strtA), .chnnl(chA), .IR_en(irA), .LEDs(ledsA),
        .lft(lftA), .rht(rhtA), .upd(updA), .a2d_err(errA)
    );

    line_follow_pi #(
        .NUM_PAIRS(1), .SETTLE_CYC(8), .INT_DEC(4), .MOT_W(12), .CNV_TO(20)
    ) dutB (
        .clk(clk), .rst(rst), .go(goB), .cnv_cmplt(cnvB), .A2D_res(resB),
        .strt_cnv(strtB), .chnnl(chB), .IR_en(irB), .LEDs(ledsB),
        .lft(lftB), .rht(rhtB), .upd(updB), .a2d_err(errB)
    );

    // A2D responder for instance A: answers each strt_cnv three cycles later unless withheld.
    logic [11:0] chValA [0:7];
    logic [7:0]  withholdA = 8'h00;
    logic        adcBusyA = 1'b0;
    int          adcDelayA = 0;
    logic [2:0]  adcChA = 3'd0;
    logic [2:0]  chLogA [0:1023];
    int          logCountA = 0;
    int          updCountA = 0;

    always @(negedge clk) begin
        cnvA = 1'b0;
        if (adcBusyA) begin
            if (adcDelayA == 0) begin
                adcBusyA = 1'b0;
                if (!withholdA[adcChA]) begin
                    cnvA = 1'b1;
                    resA = chValA[adcChA];
                end
            end else begin
                adcDelayA = adcDelayA - 1;
            end
        end
        if (strtA) begin
            adcBusyA  = 1'b1;
            adcDelayA = 2;
            adcChA    = chA;
            chLogA[logCountA % 1024] = chA;
            logCountA = logCountA + 1;
        end
        if (updA) updCountA = updCountA + 1;
    end

    // Responder for instance B, which also tallies any channel outside the 0,1,0,1 pattern.
    logic [11:0] chValB [0:1];
    logic        adcBusyB = 1'b0;
    int          adcDelayB = 0;
    logic        adcChB = 1'b0;
    int          logCountB = 0;
    int          badChB = 0;

    always @(negedge clk) begin
        cnvB = 1'b0;
        if (adcBusyB) begin
            if (adcDelayB == 0) begin
                adcBusyB = 1'b0;
                cnvB     = 1'b1;
                resB     = chValB[adcChB];
            end else begin
                adcDelayB = adcDelayB - 1;
            end
        end
        if (strtB) begin
            adcBusyB  = 1'b1;
            adcDelayB = 2;
            adcChB    = chB[0];
            if (int'(chB) != (logCountB % 2)) badChB = badChB + 1;
            logCountB = logCountB + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic gA, input logic gB);
        rst = r;
        goA = gA;
        goB = gB;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // 0:updA 1:updB 2:errA 3:IR_en==pair1 on A, otherwise strt_cnv on A
    task automatic waitFor(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick(1);
            case (which)
                0:       seen = updA;
                1:       seen = updB;
                2:       seen = errA;
                3:       seen = (irA == 3'b010);
                default: seen = strtA;
            endcase
        end
        checkOutput({tag, "_seen"}, 16'(seen), 16'd1);
    endtask

    initial begin
        int          base;
        int          updBase;
        logic [17:0] word;

        for (int i = 0; i < 8; i++) chValA[i] = 12'h000;
        chValB[0] = 12'd100;
        chValB[1] = 12'd0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(2);
        checkOutput("rst_strt",  16'(strtA), 16'd0);
        checkOutput("rst_chnnl", 16'(chA),   16'd0);
        checkOutput("rst_ir",    16'(irA),   16'd0);
        checkOutput("rst_leds",  16'(ledsA), 16'd0);
        checkOutput("rst_lft",   16'(lftA),  16'd0);
        checkOutput("rst_rht",   16'(rhtA),  16'd0);
        checkOutput("rst_upd",   16'(updA),  16'd0);
        checkOutput("rst_err",   16'(errA),  16'd0);
        checkOutput("rst_irB",   16'(irB),   16'd0);
        checkOutput("rst_errB",  16'(errB),  16'd0);

        $display("[TB] single pair, integrator");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitFor(1, "b_upd1");
        checkOutput("b_lft1",  16'(lftB),  16'd338);
        checkOutput("b_rht1",  16'(rhtB),  16'd0);
        checkOutput("b_leds1", 16'(ledsB), 16'h06);
        waitFor(1, "b_upd2");
        waitFor(1, "b_upd3");
        waitFor(1, "b_upd4");
        checkOutput("b_lft4", 16'(lftB), 16'd372);
        waitFor(1, "b_upd5");
        checkOutput("b_lft5", 16'(lftB), 16'd373);
        waitFor(1, "b_upd6");
        waitFor(1, "b_upd7");
        waitFor(1, "b_upd8");
        checkOutput("b_lft8",   16'(lftB),      16'd407);
        checkOutput("b_nconv",  16'(logCountB), 16'd16);
        checkOutput("b_badch",  16'(badChB),    16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] flat line, forward ramp");
        for (int i = 0; i < 8; i++) chValA[i] = 12'h100;
        base = logCountA;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor(0, "a_upd1");
        word = '0;
        for (int i = 0; i < 6; i++) word = {word[14:0], chLogA[(base + i) % 1024]};
        checkOutput("a_nconv", 16'(logCountA - base), 16'd6);
        checkOutput("a_chseq", 16'(word[17:2]), 16'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5} >> 2));
        checkOutput("a_chseq_lo", 16'(word[1:0]), 16'd1);
        checkOutput("a_leds1", 16'(ledsA), 16'd0);
        checkOutput("a_lft1",  16'(lftA),  16'd0);
        checkOutput("a_rht1",  16'(rhtA),  16'd0);
        waitFor(0, "a_upd2");
        checkOutput("a_lft2", 16'(lftA), 16'd1);
        checkOutput("a_rht2", 16'(rhtA), 16'd1);
        for (int n = 3; n <= 6; n++) waitFor(0, "a_updn");
        checkOutput("a_lft6", 16'(lftA), 16'd3);
        waitFor(0, "a_upd7");
        waitFor(0, "a_upd8");
        checkOutput("a_lft8_ceiling", 16'(lftA), 16'd3);
        checkOutput("a_rht8_ceiling", 16'(rhtA), 16'd3);

        $display("[TB] conversion timeout on channel 3");
        withholdA[3] = 1'b1;
        updBase = updCountA;
        waitFor(2, "to_err");
        checkOutput("to_errflag", 16'(errA), 16'd1);
        checkOutput("to_chnnl",   16'(chA),  16'd3);
        checkOutput("to_ir",      16'(irA),  16'd0);
        checkOutput("to_lft",     16'(lftA), 16'd3);
        checkOutput("to_rht",     16'(rhtA), 16'd3);
        checkOutput("to_noupd",   16'(updCountA - updBase), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("stop_err", 16'(errA), 16'd0);
        checkOutput("stop_lft", 16'(lftA), 16'd0);
        checkOutput("stop_rht", 16'(rhtA), 16'd0);
        checkOutput("stop_ir",  16'(irA),  16'd0);
        withholdA[3] = 1'b0;
        tick(10);

        $display("[TB] saturation");
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);
        for (int i = 0; i < 8; i++) chValA[i] = 12'h000;
        chValA[4] = 12'hFFF;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor(0, "satp_upd");
        checkOutput("satp_leds", 16'(ledsA), 16'h7F);
        checkOutput("satp_lft",  16'(lftA),  16'h7FF);
        checkOutput("satp_rht",  16'(rhtA),  16'h000);
        chValA[4] = 12'h000;
        chValA[5] = 12'hFFF;
        waitFor(0, "satn_upd");
        checkOutput("satn_leds", 16'(ledsA), 16'h80);
        checkOutput("satn_lft",  16'(lftA),  16'h000);
        checkOutput("satn_rht",  16'(rhtA),  16'h7FF);

        $display("[TB] go dropped while settling pair 1");
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(10);
        for (int i = 0; i < 8; i++) chValA[i] = 12'h000;
        chValA[0] = 12'd100;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor(0, "drop_upd1");
        checkOutput("drop_lft1",  16'(lftA),  16'd169);
        checkOutput("drop_rht1",  16'(rhtA),  16'd0);
        checkOutput("drop_leds1", 16'(ledsA), 16'h06);
        waitFor(3, "drop_pair1");
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("drop_ir",   16'(irA),   16'd0);
        checkOutput("drop_lft",  16'(lftA),  16'd0);
        checkOutput("drop_rht",  16'(rhtA),  16'd0);
        checkOutput("drop_strt", 16'(strtA), 16'd0);
        checkOutput("drop_leds", 16'(ledsA), 16'h06);
        tick(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitFor(4, "restart_strt");
        checkOutput("restart_chnnl", 16'(chA), 16'd0);
        checkOutput("restart_ir",    16'(irA), 16'b001);
        waitFor(0, "restart_upd");
        checkOutput("restart_lft", 16'(lftA), 16'd169);

        $display("[TB] reset mid-conversion");
        waitFor(4, "mid_strt");
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("mid_strt_clr", 16'(strtA), 16'd0);
        checkOutput("mid_chnnl",    16'(chA),   16'd0);
        checkOutput("mid_ir",       16'(irA),   16'd0);
        checkOutput("mid_leds",     16'(ledsA), 16'd0);
        checkOutput("mid_lft",      16'(lftA),  16'd0);
        checkOutput("mid_upd",      16'(updA),  16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
